// File: rtl/aes_key_expand.sv
// Iterative AES key-schedule engine (AES-128/192/256, selected at run time).
// Expands one cipher key into the full round-key schedule, one 32-bit word
// per clock, and keeps every word in local registers.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, mode     launch request (sampled in IDLE); key length 0/1/2 = 128/192/256
//   key             cipher key, MSB word is w[0], shorter keys left-aligned
//   busy            expansion in progress
//   done, err       one-cycle pulses: schedule complete / start rejected
//   key_valid, nr   stored schedule is readable; its round count (10/12/14)
//   rk_idx, rk_data round-key read port (combinational, 0 when not readable)
module aes_key_expand #(
  parameter int NK_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [32*NK_MAX-1:0]  key,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  key_valid,
  output logic [3:0]            nr,
  input  logic [3:0]            rk_idx,
  output logic [127:0]          rk_data
);

  localparam int DEPTH = 4 * (NK_MAX + 7);
  localparam int IW    = $clog2(DEPTH);

  // Forward S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    logic [31:0] r;
    r = '0;
    // ~b selects the byte counted from the top of the table
    for (int b = 0; b < 4; b++) r[8*b +: 8] = SBOX[{~x[8*b +: 8], 3'b000} +: 8];
    return r;
  endfunction

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t          state;
  logic [31:0]     w [DEPTH];
  logic [IW-1:0]   i, last;
  logic [3:0]      j, nk, nr_run;
  logic [7:0]      rcon;

  // Mode decode
  logic [3:0] mode_nk, mode_nr;
  logic       mode_ok;
  always_comb begin
    case (mode)
      2'd0:    mode_nk = 4'd4;
      2'd1:    mode_nk = 4'd6;
      2'd2:    mode_nk = 4'd8;
      default: mode_nk = 4'd0;
    endcase
    mode_nr = mode_nk + 4'd6;
    mode_ok = (mode_nk != 4'd0) && (mode_nk <= 4'(NK_MAX));
  end

  wire accept = (state == IDLE) && start && mode_ok;

  // Next schedule word. One S-box row is shared between the RotWord path
  // (j==0) and the extra AES-256 SubWord at j==4.
  logic [IW-1:0] idx_prev, idx_back;
  logic [31:0]   prev, sub_in, sub_out, temp, new_word;
  always_comb begin
    idx_prev = i - IW'(1);
    idx_back = i - IW'(nk);
    prev     = w[idx_prev];
    sub_in   = (j == 4'd0) ? {prev[23:0], prev[31:24]} : prev;
    sub_out  = sub_word(sub_in);
    if (j == 4'd0)                     temp = sub_out ^ {rcon, 24'h0};
    else if (nk == 4'd8 && j == 4'd4)  temp = sub_out;
    else                               temp = prev;
    new_word = w[idx_back] ^ temp;
  end

  // Word storage: deliberately not reset; the read port masks it instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) begin
        for (int k = 0; k < NK_MAX; k++)
          if (4'(k) < mode_nk) w[k] <= key[32*(NK_MAX-1-k) +: 32];
      end else if (state == EXPAND) begin
        w[i] <= new_word;
      end
    end
  end

  // Control FSM
  always_ff @(posedge clk) begin
    done <= 1'b0;
    err  <= 1'b0;
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      key_valid <= 1'b0;
      nr        <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (mode_ok) begin
              i         <= IW'(mode_nk);
              j         <= 4'd0;
              rcon      <= 8'h01;
              nk        <= mode_nk;
              nr_run    <= mode_nr;
              last      <= IW'({mode_nr, 2'b11});   // 4*(Nr+1)-1
              key_valid <= 1'b0;
              busy      <= 1'b1;
              state     <= EXPAND;
            end else begin
              err <= 1'b1;
            end
          end
        end
        EXPAND: begin
          i <= i + IW'(1);
          j <= (j == nk - 4'd1) ? 4'd0 : j + 4'd1;
          if (j == 4'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
          if (i == last) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            key_valid <= 1'b1;
            nr        <= nr_run;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Round-key read port
  logic [IW-1:0] rk_base;
  always_comb begin
    rk_base = IW'({rk_idx, 2'b00});
    rk_data = '0;
    if (key_valid && rk_idx <= nr)
      rk_data = {w[rk_base], w[rk_base + IW'(1)], w[rk_base + IW'(2)], w[rk_base + IW'(3)]};
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: known-answer table, hand-written
// corner sequences, and random keys against a FIPS-197 style reference model.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [1:0]   mode;
  logic [255:0] key;
  logic         busy, done, err, key_valid;
  logic [3:0]   nr, rk_idx;
  logic [127:0] rk_data;

  aes_key_expand #(.NK_MAX(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .key(key),
    .busy(busy), .done(done), .err(err), .key_valid(key_valid), .nr(nr),
    .rk_idx(rk_idx), .rk_data(rk_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  sbox_t [256];
  logic [31:0] mw [60];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 0; x = a; y = b;
    for (int n = 0; n < 8; n++) begin
      if (y[0]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sbox_t[v[31:24]], sbox_t[v[23:16]], sbox_t[v[15:8]], sbox_t[v[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] k, input int nk);
    logic [31:0] t;
    logic [7:0]  rc [16];
    rc[1] = 8'h01;
    for (int n = 2; n < 16; n++) rc[n] = gmul(rc[n-1], 8'h02);
    for (int n = 0; n < 60; n++) mw[n] = 0;
    for (int n = 0; n < nk; n++) mw[n] = k[255-32*n -: 32];
    for (int n = nk; n < 4 * (nk + 7); n++) begin
      t = mw[n-1];
      if (n % nk == 0)              t = subw({t[23:0], t[31:24]}) ^ {rc[n/nk], 24'h0};
      else if (nk > 6 && n % nk == 4) t = subw(t);
      mw[n] = mw[n-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] model_rk(input int idx, input int nrr);
    if (idx > nrr) return '0;
    return {mw[4*idx], mw[4*idx+1], mw[4*idx+2], mw[4*idx+3]};
  endfunction

  // ---------------- drive helpers ----------------
  task automatic launch(input logic [1:0] m, input logic [255:0] k);
    mode = m; key = k; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Bounded wait for done; lat counts edges after the current one.
  task automatic wait_done(output int lat, output int errs);
    lat = 0; errs = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (err) errs++;
    end
  endtask

  typedef struct {
    logic [1:0]   mode;
    logic [255:0] key;
    logic [3:0]   idx;
    logic [127:0] exp_rk;
    int           lat;
    logic [3:0]   nr;
  } vec_t;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] RK10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  vec_t vecs [4];
  int lat, e, lat2, dcnt;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2'd0, K128, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605, 40, 4'd10};
    vecs[1] = '{2'd0, K128, 4'd10, RK10_128,                               40, 4'd10};
    vecs[2] = '{2'd1, K192, 4'd12, 128'he98ba06f448c773c8ecc720401002202, 46, 4'd12};
    vecs[3] = '{2'd2, K256, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e, 52, 4'd14};

    build_sbox();
    rst = 1'b1; start = 1'b0; mode = 2'd0; key = '0; rk_idx = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_flags", {busy, done, err, key_valid, nr}, '0);
    chk("reset_rk", rk_data, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Known-answer table
    for (int v = 0; v < 4; v++) begin
      launch(vecs[v].mode, vecs[v].key);
      wait_done(lat, e);
      chk($sformatf("kat%0d_latency", v), 128'(lat), 128'(vecs[v].lat));
      chk($sformatf("kat%0d_nr", v), 128'(nr), 128'(vecs[v].nr));
      rk_idx = vecs[v].idx; #1;
      chk($sformatf("kat%0d_rk", v), rk_data, vecs[v].exp_rk);
      @(posedge clk); #1;
      chk($sformatf("kat%0d_done_pulse", v), {busy, done, key_valid}, 3'b001);
    end

    // Illegal mode after a completed AES-128 schedule
    launch(2'd0, K128);
    wait_done(lat, e);
    launch(2'd3, K256);
    chk("illegal_err", {err, busy}, 2'b10);
    @(posedge clk); #1;
    chk("illegal_err_one_cycle", err, 0);
    chk("illegal_key_valid", {key_valid, nr}, {1'b1, 4'd10});
    rk_idx = 4'd10; #1;
    chk("illegal_rk10", rk_data, RK10_128);
    rk_idx = 4'd11; #1;
    chk("rk_idx_over_nr", rk_data, '0);

    // Reset 20 cycles into an AES-256 run
    launch(2'd2, K256);
    repeat (19) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rk_idx = 4'd0; #1;
    chk("abort_flags", {busy, done, err, key_valid, nr}, '0);
    chk("abort_rk", rk_data, '0);
    dcnt = 0;
    repeat (60) begin @(posedge clk); #1; if (done || key_valid) dcnt++; end
    chk("abort_no_done", 128'(dcnt), 0);
    launch(2'd0, K128);
    wait_done(lat, e);
    chk("abort_rerun_latency", 128'(lat), 40);
    rk_idx = 4'd10; #1;
    chk("abort_rerun_rk10", rk_data, RK10_128);

    // start re-pulsed mid-expansion is ignored
    model_expand(K128, 4);
    launch(2'd0, K128);
    repeat (10) begin @(posedge clk); #1; end
    start = 1'b1; mode = 2'd2;
    @(posedge clk); #1;
    start = 1'b0;
    e = err ? 1 : 0;
    wait_done(lat2, lat);
    chk("repulse_no_err", 128'(e + lat), 0);
    chk("repulse_latency", 128'(11 + lat2), 40);
    rk_idx = 4'd5; #1;
    chk("repulse_rk5", rk_data, model_rk(5, 10));

    // start on the done cycle is accepted (done currently high)
    model_expand(K192, 6);
    mode = 2'd1; key = K192; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_cycle_restart", {key_valid, busy}, 2'b01);
    wait_done(lat, e);
    chk("done_cycle_latency", 128'(lat), 46);
    rk_idx = 4'd12; #1;
    chk("done_cycle_rk12", rk_data, model_rk(12, 12));

    // Random keys against the model
    for (int r = 0; r < 6; r++) begin
      logic [1:0]   m;
      logic [255:0] k;
      int           nk;
      m  = 2'($urandom_range(0, 2));
      nk = 4 + 2 * int'(m);
      for (int q = 0; q < 8; q++) k[32*q +: 32] = $urandom;
      model_expand(k, nk);
      launch(m, k);
      wait_done(lat, e);
      chk($sformatf("rnd%0d_latency", r), 128'(lat), 128'(4 * (nk + 7) - nk));
      for (int x = 0; x < 16; x++) begin
        rk_idx = 4'(x); #1;
        chk($sformatf("rnd%0d_rk%0d", r, x), rk_data, model_rk(x, nk + 6));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative, runtime-configurable AES key-schedule engine: expands one 128/192/256-bit cipher key into all round keys.
- Produces one 32-bit schedule word per clock and holds the full schedule in local registers.
- Sits beside the AES top-level controller. The controller launches an expansion and then reads round keys by index during cipher and inverse-cipher passes.

Parameters:
- NK_MAX, 8, largest supported key length in 32-bit words (legal values 4, 6, 8). Sets the key port width and the storage depth of 4*(NK_MAX+7) words.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  launch request, sampled only in IDLE
- mode  in  2  key length: 0=AES-128 (Nk=4), 1=AES-192 (Nk=6), 2=AES-256 (Nk=8), 3=illegal
- key  in  32*NK_MAX  cipher key; the MSB word is w[0]; shorter keys are left-aligned
- busy  out  1  high while state is EXPAND
- done  out  1  one-cycle pulse when the schedule completes
- err  out  1  one-cycle pulse on a rejected start
- key_valid  out  1  schedule complete and readable
- nr  out  4  round count of the stored schedule (10/12/14)
- rk_idx  in  4  round-key index to read
- rk_data  out  128  round key {w[4*rk_idx], w[4*rk_idx+1], w[4*rk_idx+2], w[4*rk_idx+3]}, combinational from rk_idx

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - state=IDLE.
  - busy, done, err, key_valid = 0; nr=0.
  - Word storage is not cleared, but rk_data is forced to 0 while key_valid=0.
- Reset during EXPAND aborts immediately. key_valid stays 0 and no done pulse is produced.
- States: IDLE, EXPAND.
- IDLE handling of start=1 (mode selects Nk; Nr=Nk+6):
  - Legal mode with Nk<=NK_MAX, at the sampling edge:
    - load w[0..Nk-1] from the key MSB words;
    - i=Nk, j=0 (i mod Nk), rcon=0x01;
    - latch Nk and Nr; key_valid=0;
    - go to EXPAND.
  - Otherwise: err=1 for one cycle; state, key_valid, nr and storage are unchanged.
- EXPAND: each edge writes w[i] = w[i-Nk] XOR temp, where temp is:
  - j==0: SubWord(RotWord(w[i-1])) XOR {rcon,24'h0}; afterwards rcon=xtime(rcon) (0x80 -> 0x1b).
  - Nk==8 and j==4: SubWord(w[i-1]).
  - Otherwise: w[i-1].
  - After each write, i+1; j wraps to 0 at Nk. No division or modulo logic is used.
- Completion:
  - The last word is i = 4*(Nr+1)-1, i.e. 43, 51 or 59.
  - At that edge: state=IDLE, done=1 for exactly one cycle, key_valid=1, nr=Nr.
  - Latency from the start-sampling edge to done visible: 40, 46 or 52 cycles for AES-128/192/256.
- start while busy is ignored: no err, and the expansion continues undisturbed.
- start in the same cycle that done is high is accepted normally, since state is already IDLE.
- SubWord uses the codebase forward S-box on each of the 4 bytes. RotWord rotates left by one byte.
- rk_data returns 0 when key_valid=0 or rk_idx>nr.
- rk_data is valid and stable from the cycle done is high until the next accepted start.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c:
  - done exactly 40 cycles after start; nr=10.
  - rk_idx=1 -> a0fafe1788542cb123a339392a6c7605.
  - rk_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - done after 46 cycles; nr=12.
  - rk_idx=12 -> e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - done after 52 cycles; nr=14.
  - rk_idx=14 -> fe4890d1e6188d0b046df344706c631e.
- mode=3 with start=1 after a completed AES-128 schedule:
  - err pulses for 1 cycle; busy stays 0.
  - key_valid stays 1; rk_idx=10 still returns d014f9a8...
- Reset asserted 20 cycles into an AES-256 run:
  - All outputs are 0 the next cycle; no done pulse ever appears; rk_data=0.
  - A fresh AES-128 start then completes in 40 cycles.
- Bounds and collisions:
  - start re-pulsed mid-EXPAND is ignored (no err; same done timing).
  - rk_idx=11 with nr=10 -> rk_data=0.
  - start on the done cycle -> key_valid drops next cycle and a new run completes.
